// File: rtl/demux_1b_1to8_dispatch_pkg.sv
// Shared types and constants for the 1-to-8 demux dispatch front end.
package demux_1b_1to8_dispatch_pkg;
  localparam int NCHAN      = 8;
  localparam int SEL_W      = 3;
  localparam int NBITS_DFLT = 1;

  typedef enum logic {
    MODE_DIRECTED = 1'b0,
    MODE_SPREAD   = 1'b1
  } mode_e;

  typedef logic [SEL_W-1:0] sel_t;

  // The 8-bit variant widens NBITS_DFLT; the FIFO entry follows it.
  typedef struct packed {
    logic [NBITS_DFLT-1:0] msg;
    sel_t                  dest;
  } entry_t;
endpackage

// File: rtl/demux_1b_1to8_dispatch_if.sv
// Producer / consumer bundle of the dispatch block; slave is the block's view.
interface demux_1b_1to8_dispatch_if
  import demux_1b_1to8_dispatch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NBITS = NBITS_DFLT
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   in_val;
  logic                   in_rdy;
  logic [NBITS-1:0]       in_msg;
  sel_t                   in_dest;
  logic                   mode;
  logic                   clear;
  logic [NCHAN-1:0]       out_val;
  logic [NCHAN-1:0]       out_rdy;
  logic [NCHAN*NBITS-1:0] out_msg;
  sel_t                   sel;
  sel_t                   rr_ptr;
  logic [CNT_W-1:0]       count;

  modport master (
    output in_val, in_msg, in_dest, mode, clear, out_rdy,
    input  in_rdy, out_val, out_msg, sel, rr_ptr, count
  );

  modport slave (
    input  in_val, in_msg, in_dest, mode, clear, out_rdy,
    output in_rdy, out_val, out_msg, sel, rr_ptr, count
  );
endinterface

// File: rtl/demux_1b_1to8_dispatch_fifo.sv
// DEPTH-entry synchronous FIFO of dispatch entries with flush and occupancy count.
module demux_1b_1to8_dispatch_fifo
  import demux_1b_1to8_dispatch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over everything; a same-cycle pop is implicitly absorbed.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/demux_1b_1to8_dispatch.sv
// Dispatch front end: buffers 1-bit items and steers each to one of eight
// back-pressured channels, either by request or by a round-robin pointer.
module demux_1b_1to8_dispatch
  import demux_1b_1to8_dispatch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NBITS = NBITS_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  demux_1b_1to8_dispatch_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t             head;
  entry_t             wdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic               spread;
  sel_t               rr_ptr_q, rr_ptr_d;
  sel_t               sel_q, sel_d;

  assign spread = (mode_e'(bus.mode) == MODE_SPREAD);

  always_comb begin
    bus.in_rdy = !fifo_full && !bus.clear;
    push       = bus.in_val && bus.in_rdy;
    pop        = !fifo_empty && bus.out_rdy[head.dest];
    wdata.msg  = bus.in_msg;
    wdata.dest = spread ? rr_ptr_q : bus.in_dest;
  end

  demux_1b_1to8_dispatch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (bus.clear),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clear takes priority over the spread-mode advance.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (bus.clear) begin
      rr_ptr_d = '0;
    end else if (push && spread) begin
      rr_ptr_d = rr_ptr_q + sel_t'(1);
    end
  end

  // sel follows the head and holds its last value while the FIFO is empty.
  always_comb begin
    sel_d = fifo_empty ? sel_q : head.dest;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    bus.out_val = '0;
    bus.out_msg = '0;
    if (!fifo_empty) begin
      bus.out_val[head.dest]                          = 1'b1;
      bus.out_msg[int'(head.dest)*NBITS +: NBITS]     = head.msg;
    end
    bus.sel    = sel_d;
    bus.rr_ptr = rr_ptr_q;
    bus.count  = fifo_count;
  end
endmodule

// File: tb/tb_demux_1b_1to8_dispatch.sv
// Directed and randomized checks of the dispatch block against a queue model.
module tb_demux_1b_1to8_dispatch;
  import demux_1b_1to8_dispatch_pkg::*;

  localparam int DEPTH = 2;
  localparam int NB    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_1b_1to8_dispatch_if #(.DEPTH(DEPTH), .NBITS(NB)) bus ();

  demux_1b_1to8_dispatch #(.DEPTH(DEPTH), .NBITS(NB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic msg;
    int   dest;
  } item_t;

  item_t q[$];
  int    m_rr  = 0;
  int    m_sel = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] ev;
    logic [7:0] em;
    ev = '0;
    em = '0;
    if (q.size() > 0) begin
      m_sel          = q[0].dest;
      ev[q[0].dest]  = 1'b1;
      em[q[0].dest]  = q[0].msg;
    end
    chk("out_val", 32'(bus.out_val), 32'(ev));
    chk("out_msg", 32'(bus.out_msg), 32'(em));
    chk("sel",     32'(bus.sel),     32'(m_sel));
    chk("rr_ptr",  32'(bus.rr_ptr),  32'(m_rr));
    chk("count",   32'(bus.count),   32'(q.size()));
  endtask

  // One clock of stimulus: drive at negedge, check in_rdy, model the edge, check outputs.
  task automatic cycle(input logic v, input logic m, input int d, input logic md,
                       input logic clr, input logic [7:0] rdy);
    logic  pop;
    logic  acc;
    item_t it;
    bus.in_val  = v;
    bus.in_msg  = m;
    bus.in_dest = 3'(d);
    bus.mode    = md;
    bus.clear   = clr;
    bus.out_rdy = rdy;
    #1;
    chk("in_rdy", 32'(bus.in_rdy), 32'((q.size() != DEPTH) && !clr));
    @(posedge clk);
    pop = (q.size() > 0) && rdy[q[0].dest];
    acc = v && (q.size() < DEPTH) && !clr;
    if (clr) begin
      q.delete();
      m_rr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        it.msg  = m;
        it.dest = md ? m_rr : d;
        q.push_back(it);
        if (md) m_rr = (m_rr + 1) % 8;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    bus.in_val  = 1'b0;
    bus.in_msg  = 1'b0;
    bus.in_dest = 3'd0;
    bus.mode    = 1'b0;
    bus.clear   = 1'b0;
    bus.out_rdy = 8'h00;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("in_rdy_reset", 32'(bus.in_rdy), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed fill with no drain, then drain in order.
    cycle(1, 1, 3, 0, 0, 8'h00);
    cycle(1, 0, 5, 0, 0, 8'h00);
    cycle(1, 1, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'hFF);
    cycle(0, 0, 0, 0, 0, 8'hFF);
    cycle(0, 0, 0, 0, 0, 8'h00);

    // Round-robin spread across the wrap point.
    for (int i = 0; i < 10; i++) cycle(1, 1, 6, 1, 0, 8'hFF);
    cycle(0, 0, 0, 1, 0, 8'hFF);

    // Head-of-line block then release.
    cycle(1, 1, 2, 0, 0, 8'b0100_0000);
    cycle(1, 0, 6, 0, 0, 8'b0100_0000);
    cycle(0, 0, 0, 0, 0, 8'b0100_0000);
    cycle(0, 0, 0, 0, 0, 8'b0100_0100);
    cycle(0, 0, 0, 0, 0, 8'b0100_0100);

    // Clear, then switch to directed mode.
    cycle(1, 1, 0, 1, 0, 8'hFF);
    cycle(1, 0, 0, 1, 0, 8'hFF);
    cycle(1, 1, 0, 1, 0, 8'h00);
    cycle(1, 1, 4, 1, 1, 8'hFF);
    cycle(1, 1, 7, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 0, 8'h80);

    // Asynchronous reset with two items held.
    cycle(1, 1, 1, 0, 0, 8'h00);
    cycle(1, 1, 2, 1, 0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_val", 32'(bus.out_val), 32'd0);
    chk("async_count",   32'(bus.count),   32'd0);
    chk("async_rr_ptr",  32'(bus.rr_ptr),  32'd0);
    chk("async_sel",     32'(bus.sel),     32'd0);
    q.delete();
    m_rr  = 0;
    m_sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 5, 1, 0, 8'h00);
    cycle(0, 0, 0, 1, 0, 8'h01);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 15) == 0),
            8'($urandom) | 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
